// File: rtl/bram_rr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_rr_ctrl_pkg
// Purpose  : Shared definitions for bram_rr_ctrl: controller state encoding,
//            the LOG2 helper and the derivation of the reserved SCRATCH word.
// Revision : 1.0  initial release
// ============================================================================
package bram_rr_ctrl_pkg;

  // INIT clears the memory after reset; RUN serves reads and writes.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ceiling log2, never below 1 so that every index/address bus has width.
  function automatic int LOG2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // The top word of the memory is sacrificed as a dump target for the
  // write port on cycles where only a read needs the BRAM enabled.
  function automatic int SCRATCH_ADDR(input int depth);
    return depth - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rr_ctrl_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick. Grants the first requesting
//            index at or after ptr_i, wrapping modulo N.
// Ports    : req_i  [N]   request vector
//            ptr_i  [IW]  priority pointer (held by the caller)
//            gnt_o  [N]   one-hot grant (all zero when nothing requests)
//            idx_o  [IW]  encoded index of the grant (0 when no grant)
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_rr_ctrl
// Purpose  : Single-port-pair BRAM controller. Clears the memory after reset,
//            then arbitrates NUM_REQ read requesters round-robin (one read per
//            cycle, latency 1) alongside a ready/valid write port.
// Ports    : clk, rst_n (async, active low)
//            rd_req/rd_addr/rd_gnt         read requesters
//            rsp_valid/rsp_data            read responses (one cycle after gnt)
//            wr_valid/wr_ready/wr_addr/wr_data  write handshake
//            init_done                     clear sweep finished
//            bram_*                        BRAM instance interface
// Config   : BRAM_RR_CTRL_WR_FWD_EN - when defined, a read and an accepted
//            write to the same address in one cycle return the new data.
// Revision : 1.0  initial release
// ============================================================================
module bram_rr_ctrl
  import bram_rr_ctrl_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int DEPTH   = 256,
  parameter  int NUM_REQ = 4,   // legal range 2..8
  localparam int AW      = LOG2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    rd_req,
  input  logic [NUM_REQ*AW-1:0] rd_addr,
  output logic [NUM_REQ-1:0]    rd_gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  init_done,
  output logic                  bram_clk_en,
  output logic [AW-1:0]         bram_wr_addr,
  output logic [WIDTH-1:0]      bram_wr_data,
  output logic [AW-1:0]         bram_rd_addr,
  input  logic [WIDTH-1:0]      bram_rd_data
);

  localparam int            IW      = LOG2(NUM_REQ);
  localparam logic [AW-1:0] SCRATCH = AW'(SCRATCH_ADDR(DEPTH));

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [AW-1:0]        rd_addr_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic [AW-1:0]        gnt_addr;
  logic                 wr_ok;
  logic                 rd_any;
  logic                 wr_acc;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i (rd_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign gnt_addr = rd_addr[pick_idx*AW +: AW];
  // Writes to SCRATCH are never accepted: that word belongs to the controller.
  assign wr_ok    = (wr_addr != SCRATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rd_gnt;
      rd_addr_q   <= bram_rd_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    rd_gnt       = '0;
    wr_ready     = 1'b0;
    rd_any       = 1'b0;
    wr_acc       = 1'b0;
    bram_clk_en  = 1'b0;
    bram_wr_addr = SCRATCH;
    bram_wr_data = '0;
    bram_rd_addr = rd_addr_q;
    case (state_q)
      ST_INIT: begin
        bram_clk_en  = 1'b1;
        bram_wr_addr = cnt_q;
        if (cnt_q == SCRATCH) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        wr_ready = wr_ok;
        wr_acc   = wr_valid && wr_ok;
        rd_any   = |pick_gnt;
        rd_gnt   = pick_gnt;
        if (rd_any) begin
          bram_rd_addr = gnt_addr;
          ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
        end
        // A read alone still enables the write port; it then lands a zero in
        // SCRATCH instead of corrupting live data.
        if (wr_acc) begin
          bram_wr_addr = wr_addr;
          bram_wr_data = wr_data;
        end
        bram_clk_en = rd_any || wr_acc;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign init_done = (state_q == ST_RUN);

`ifdef BRAM_RR_CTRL_WR_FWD_EN
  // The BRAM is read-first, so a colliding write is captured here and
  // substituted for the stale BRAM output on the response cycle.
  logic             fwd_hit_q;
  logic [WIDTH-1:0] fwd_data_q;
  logic             fwd_hit;

  assign fwd_hit = rd_any && wr_acc && (gnt_addr == wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q <= fwd_hit;
      if (fwd_hit) fwd_data_q <= wr_data;
    end
  end

  assign rsp_data = fwd_hit_q ? fwd_data_q : bram_rd_data;
`else
  assign rsp_data = bram_rd_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_rr_ctrl
// Purpose  : Self-checking bench for bram_rr_ctrl (WIDTH=16, DEPTH=16,
//            NUM_REQ=4) with a read-first BRAM model and a response
//            scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_bram_rr_ctrl;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int NR = 4;
  localparam int AW = 4;
`ifdef BRAM_RR_CTRL_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     rd_req;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_gnt;
  logic [NR-1:0]     rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              init_done;
  logic              bram_clk_en;
  logic [AW-1:0]     bram_wr_addr;
  logic [W-1:0]      bram_wr_data;
  logic [AW-1:0]     bram_rd_addr;
  logic [W-1:0]      bram_rd_data;

  always #5 clk = ~clk;

  bram_rr_ctrl #(.WIDTH(W), .DEPTH(D), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .init_done(init_done), .bram_clk_en(bram_clk_en),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data)
  );

  // Read-first BRAM: the read samples the old word before the write lands.
  logic [W-1:0] mem [D];
  initial for (int i = 0; i < D; i++) mem[i] = 16'hA500 | 16'(i);
  always @(posedge clk) begin
    if (bram_clk_en) begin
      bram_rd_data       <= mem[bram_rd_addr];
      mem[bram_wr_addr]  <= bram_wr_data;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
  endtask

  typedef struct packed {
    logic [NR-1:0] v;
    logic [W-1:0]  d;
  } exp_t;
  exp_t exp_q[$];
  logic [W-1:0] shadow [D];

  // Every entry pushed at the previous negedge must be answered this cycle.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
        chk("rsp_data",  32'(rsp_data),  32'(e.d));
      end else if (rsp_valid != '0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end
    end
  end

  function automatic logic [NR*AW-1:0] pk(input int a0, a1, a2, a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // One RUN cycle: drive after the edge, check combinational outputs at the
  // falling edge, and book the expected response.
  task automatic cyc(input logic [NR-1:0] req, input logic [NR*AW-1:0] addrs,
                     input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                     input logic [NR-1:0] exp_gnt, input logic exp_wacc);
    @(posedge clk); #1;
    rd_req = req; rd_addr = addrs; wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    chk("rd_gnt", 32'(rd_gnt), 32'(exp_gnt));
    chk("wr_ready", 32'(wr_ready), 32'(wa != AW'(D - 1)));
    chk("clk_en", 32'(bram_clk_en), 32'((exp_gnt != '0) || exp_wacc));
    if (exp_gnt != '0) begin
      exp_t e;
      int   g;
      logic [AW-1:0] a;
      g = 0;
      for (int i = 0; i < NR; i++) if (exp_gnt[i]) g = i;
      a = addrs[g*AW +: AW];
      e.v = exp_gnt;
      e.d = (FWD && exp_wacc && wa == a) ? wd : shadow[a];
      exp_q.push_back(e);
      if (!exp_wacc) begin
        chk("scratch_addr", 32'(bram_wr_addr), 32'(D - 1));
        chk("scratch_data", 32'(bram_wr_data), 32'd0);
      end
    end
    if (exp_wacc) shadow[wa] = wd;
  endtask

  // Clear sweep: 16 cycles of INIT with no grants, then init_done.
  task automatic sweep_check();
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("init_done_lo", 32'(init_done), 32'd0);
      chk("sweep_addr", 32'(bram_wr_addr), 32'(i));
      chk("sweep_en", 32'(bram_clk_en & (bram_wr_data == '0)), 32'd1);
      chk("init_gnt", 32'(rd_gnt), 32'd0);
      chk("init_wr_ready", 32'(wr_ready), 32'd0);
      if (i == D - 1) begin rd_req = '0; wr_valid = 1'b0; end
    end
    @(negedge clk);
    chk("init_done_hi", 32'(init_done), 32'd1);
    for (int i = 0; i < D; i++) shadow[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_req = '1; rd_addr = '0;
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h5555;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_gnt", 32'(rd_gnt), 32'd0);
    chk("rst_wr_addr", 32'(bram_wr_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_check();

    // Cleared memory reads back zero; finish on requester 3 so ptr = 0.
    for (int i = 0; i < D - 1; i++) begin
      logic [NR*AW-1:0] a;
      a = '0;
      a[(i % NR)*AW +: AW] = AW'(i);
      cyc(NR'(1 << (i % NR)), a, 1'b0, '0, '0, NR'(1 << (i % NR)), 1'b0);
    end
    cyc(4'b1000, pk(0, 0, 0, 0), 1'b0, '0, '0, 4'b1000, 1'b0);

    // All requesting from ptr 0: strict rotation.
    for (int k = 0; k < 8; k++)
      cyc(4'hF, pk(8, 9, 10, 11), 1'b0, '0, '0, NR'(1 << (k % NR)), 1'b0);

    // Sparse requests skip idle indices: ptr 0 -> 0, ptr 1 -> 2, ptr 3 -> 0.
    cyc(4'b0101, pk(1, 0, 2, 0), 1'b0, '0, '0, 4'b0001, 1'b0);
    cyc(4'b0101, pk(1, 0, 2, 0), 1'b0, '0, '0, 4'b0100, 1'b0);
    cyc(4'b0101, pk(1, 0, 2, 0), 1'b0, '0, '0, 4'b0001, 1'b0);

    // Write then read back.
    cyc(4'b0000, pk(0, 0, 0, 0), 1'b1, 4'd5, 16'hBEEF, 4'b0000, 1'b1);
    cyc(4'b0100, pk(0, 0, 5, 0), 1'b0, '0, '0, 4'b0100, 1'b0);

    // Same-cycle read/write collision at address 7, then plain read.
    cyc(4'b0010, pk(0, 7, 0, 0), 1'b1, 4'd7, 16'h1234, 4'b0010, 1'b1);
    cyc(4'b0010, pk(0, 7, 0, 0), 1'b0, '0, '0, 4'b0010, 1'b0);

    // Idle cycle keeps the BRAM disabled.
    cyc(4'b0000, pk(0, 0, 0, 0), 1'b0, 4'd2, 16'h0, 4'b0000, 1'b0);

    // Write to SCRATCH stalls; reads meanwhile dump zeros there.
    for (int k = 0; k < 10; k++)
      cyc(4'b0000, pk(0, 0, 0, 0), 1'b1, 4'd15, 16'hFFFF, 4'b0000, 1'b0);
    cyc(4'b0001, pk(15, 0, 0, 0), 1'b1, 4'd15, 16'hFFFF, 4'b0001, 1'b0);
    cyc(4'b0001, pk(15, 0, 0, 0), 1'b1, 4'd15, 16'hFFFF, 4'b0001, 1'b0);
    cyc(4'b0000, pk(0, 0, 0, 0), 1'b0, 4'd0, 16'h0, 4'b0000, 1'b0);
    chk("scratch_mem", 32'(mem[15]), 32'd0);

    // Reset during a granted read drops the response and restarts the sweep.
    cyc(4'b0001, pk(5, 0, 0, 0), 1'b0, '0, '0, 4'b0001, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    rd_req = '0;
    @(posedge clk); #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    chk("mid_rst_wr_addr", 32'(bram_wr_addr), 32'd0);
    rst_n = 1'b1;
    sweep_check();
    cyc(4'b0001, pk(5, 0, 0, 0), 1'b0, '0, '0, 4'b0001, 1'b0);
    cyc(4'b0000, pk(0, 0, 0, 0), 1'b0, '0, '0, 4'b0000, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_rr_ctrl.md
BRAM_RR_CTRL -- requirements
Module: bram_rr_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning the BRAM word count; address width AW = LOG2(DEPTH).
REQ-003 SHALL have parameter NUM_REQ, default 4, meaning the read requester count; the legal range is 2..8.
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have port rd_req, input, width NUM_REQ: per-requester read request.
REQ-007 SHALL have port rd_addr, input, width NUM_REQ*AW: flattened read addresses; requester i occupies bits [i*AW +: AW].
REQ-008 SHALL have port rd_gnt, output, width NUM_REQ: one-hot grant, combinational in the request cycle.
REQ-009 SHALL have port rsp_valid, output, width NUM_REQ: one-hot, marking that rsp_data belongs to requester i.
REQ-010 SHALL have port rsp_data, output, width WIDTH: read data, wired directly from bram_rd_data.
REQ-011 SHALL have port wr_valid, input, width 1, and port wr_ready, output, width 1: the write handshake.
REQ-012 SHALL have port wr_addr, input, width AW, and port wr_data, input, width WIDTH: the write request.
REQ-013 SHALL have port init_done, output, width 1: high once the memory clear sweep has completed.
REQ-014 SHALL have outputs bram_clk_en (1), bram_wr_addr (AW), bram_wr_data (WIDTH) and bram_rd_addr (AW), plus input bram_rd_data (WIDTH), all driving a BRAM instance.
- The BRAM writes on every cycle in which bram_clk_en is high.

Function
REQ-015 SHALL implement two states, INIT and RUN; reset enters INIT.
REQ-016 SHALL, in INIT, sweep a counter 0..DEPTH-1 with bram_wr_addr = counter, bram_wr_data = 0 and bram_clk_en = 1, for exactly DEPTH cycles.
- INIT SHALL then move to RUN.
REQ-017 SHALL, in INIT, hold rd_gnt = 0, wr_ready = 0 and init_done = 0.
REQ-018 SHALL reserve address SCRATCH = DEPTH-1; any cycle with a read but no accepted write SHALL drive bram_wr_addr = SCRATCH and bram_wr_data = 0.
REQ-019 SHALL, in RUN, drive wr_ready = 1 when wr_addr != SCRATCH, else 0.
- A write to SCRATCH SHALL stall indefinitely; no BRAM write occurs for it.
REQ-020 SHALL accept a write when wr_valid && wr_ready; the write lands at the next edge.
REQ-021 SHALL, in RUN, grant at most one read per cycle, round-robin from pointer ptr.
- The grant goes to the first requesting index at or after ptr, modulo NUM_REQ.
REQ-022 SHALL, on a grant to requester g, set ptr <= (g+1) mod NUM_REQ; ptr SHALL hold when there is no grant.
REQ-023 SHALL drive bram_rd_addr = the granted requester's address; with no grant it holds its last value.
REQ-024 SHALL assert rsp_valid[g] exactly one cycle after rd_gnt[g]; read latency is 1.
REQ-025 SHALL drive bram_clk_en = 1 in RUN only when a read is granted or a write is accepted; otherwise 0.
- With bram_clk_en = 0, the BRAM holds rd_data and memory.
REQ-026 SHALL, on a same-cycle read and write to the same address, return the old (pre-write) data, unless the feature in REQ-031 is compiled in.
REQ-027 SHALL, for a read of SCRATCH, grant and respond normally; the data is undefined.
REQ-028 SHALL ignore rd_req bits while rst_n is low or in INIT; requests SHALL NOT be queued.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: state = INIT, counter = 0, ptr = 0, rsp_valid = 0, init_done = 0.
- All combinational outputs SHALL follow from these values.
REQ-030 SHALL, on reset asserted mid-operation, drop any in-flight response (rsp_valid = 0) and restart the full clear sweep from address 0.

Configuration
REQ-031 SHALL provide macro BRAM_RR_CTRL_WR_FWD_EN.
- When defined: a same-cycle read and accepted write to an equal address SHALL register wr_data, and the next-cycle rsp_data SHALL be that forwarded value.
- When undefined: no forwarding register exists, and old data is returned.

Structure
REQ-032 SHALL place the state encodings (INIT, RUN) and the SCRATCH derivation in the shared definitions header, alongside LOG2.
REQ-033 SHALL factor the round-robin pick into a sub-module rr_pick.
- Inputs: req and ptr. Outputs: a one-hot gnt and the encoded index.
- The sub-module is purely combinational; ptr is held in bram_rr_ctrl.

Verification
REQ-034 SHALL cover reset release with DEPTH = 16: init_done rises after exactly 16 cycles; reads of addresses 0..14 then return 0.
REQ-035 SHALL cover NUM_REQ = 4, with rd_req = 4'b1111 held for 8 cycles from ptr = 0: grants follow 0,1,2,3,0,1,2,3, and each rsp_valid follows one cycle later.
REQ-036 SHALL cover a write of 0xBEEF to address 5, then requester 2 reading address 5 one cycle later: rsp_valid[2] = 1 and rsp_data = 0xBEEF.
REQ-037 SHALL cover a same-cycle write of 0x1234 and a read, both to address 7, which holds 0x0000:
- Without BRAM_RR_CTRL_WR_FWD_EN, rsp_data = 0x0000.
- With BRAM_RR_CTRL_WR_FWD_EN, rsp_data = 0x1234.
REQ-038 SHALL cover wr_valid = 1 with wr_addr = 15 (DEPTH = 16): wr_ready stays 0 for 10 cycles, and address 15 receives only scratch zeros.
REQ-039 SHALL cover rst_n pulsed low during a granted read: rsp_valid is 0 the next cycle, init_done is 0, and the sweep restarts at address 0.
